// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Function : MIPS32-style execute stage; operand select, ALU, branch condition
//            and the EX/MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] Imm,
  input  logic [31:0] NPC_id,
  input  logic [31:0] IR_id,
  output logic [31:0] NPC_ex,
  output logic [31:0] IR_ex,
  output logic [31:0] ALU_res,
  output logic [31:0] B_ex,
  output logic        cond
);

  localparam logic [5:0] c_op_load  = 6'h30;
  localparam logic [5:0] c_op_store = 6'h31;
  localparam logic [5:0] c_op_beqz  = 6'h34;
  localparam logic [5:0] c_op_bneqz = 6'h35;

  localparam logic [2:0] c_fn_add = 3'd0;
  localparam logic [2:0] c_fn_sub = 3'd1;
  localparam logic [2:0] c_fn_and = 3'd2;
  localparam logic [2:0] c_fn_or  = 3'd3;
  localparam logic [2:0] c_fn_slt = 3'd4;
  localparam logic [2:0] c_fn_mul = 3'd5;

  logic [5:0]  w_op;
  logic [2:0]  w_fn;
  logic        w_alu_en;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] w_alu_res;
  logic        cond_next;

  assign w_op = IR_id[31:26];

  // Opcodes outside the decoded set keep the register operands but disable the ALU.
  always_comb begin
    a        = A;
    b        = B;
    w_fn     = c_fn_add;
    w_alu_en = 1'b0;
    case (w_op) inside
      [6'h00:6'h05]: begin
        w_fn     = w_op[2:0];
        w_alu_en = 1'b1;
      end
      [6'h10:6'h15]: begin
        b        = Imm;
        w_fn     = w_op[2:0];
        w_alu_en = 1'b1;
      end
      c_op_load, c_op_store: begin
        b        = Imm;
        w_alu_en = 1'b1;
      end
      c_op_beqz, c_op_bneqz: begin
        a        = NPC_id;
        b        = Imm;
        w_alu_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_res = 32'd0;
    if (w_alu_en) begin
      case (w_fn)
        c_fn_add: w_alu_res = a + b;
        c_fn_sub: w_alu_res = a - b;
        c_fn_and: w_alu_res = a & b;
        c_fn_or:  w_alu_res = a | b;
        c_fn_slt: w_alu_res = {31'd0, ($signed(a) < $signed(b))};
        c_fn_mul: w_alu_res = a * b;
        default:  w_alu_res = 32'd0;
      endcase
    end
  end

  // Branch test looks at the rs operand, not at the NPC-carrying ALU input.
  assign cond_next = ((w_op == c_op_beqz)  && (A == 32'd0)) ||
                     ((w_op == c_op_bneqz) && (A != 32'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      NPC_ex  <= 32'd0;
      IR_ex   <= 32'd0;
      ALU_res <= 32'd0;
      B_ex    <= 32'd0;
      cond    <= 1'b0;
    end else begin
      NPC_ex  <= NPC_id;
      IR_ex   <= IR_id;
      ALU_res <= w_alu_res;
      B_ex    <= B;
      cond    <= cond_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage
// Function : scoreboard bench for exe_stage with directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = 32'd0, B = 32'd0, Imm = 32'd0, NPC_id = 32'd0, IR_id = 32'd0;
  logic [31:0] NPC_ex, IR_ex, ALU_res, B_ex;
  logic        cond;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] opa, opb, npc, ir, alu, bex;
    logic        cnd;
  } exp_t;

  exp_t q[$];
  exp_t m;

  exe_stage dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Imm(Imm), .NPC_id(NPC_id), .IR_id(IR_id),
    .NPC_ex(NPC_ex), .IR_ex(IR_ex), .ALU_res(ALU_res), .B_ex(B_ex), .cond(cond)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: instruction semantics from the opcode tables, plain arithmetic.
  function automatic exp_t model(input logic [31:0] ra, rb, imm, npc, ir);
    exp_t e;
    int   fn;
    logic [5:0] op;
    op    = ir[31:26];
    fn    = -1;
    e.opa = ra;
    e.opb = rb;
    if (op <= 6'd5) fn = int'(op);
    else if (op >= 6'h10 && op <= 6'h15) begin fn = int'(op) - 16; e.opb = imm; end
    else if (op == 6'h30 || op == 6'h31) begin fn = 0; e.opb = imm; end
    else if (op == 6'h34 || op == 6'h35) begin fn = 0; e.opa = npc; e.opb = imm; end
    case (fn)
      0: e.alu = e.opa + e.opb;
      1: e.alu = e.opa - e.opb;
      2: e.alu = e.opa & e.opb;
      3: e.alu = e.opa | e.opb;
      4: e.alu = ($signed(e.opa) < $signed(e.opb)) ? 32'd1 : 32'd0;
      5: e.alu = 32'(64'(e.opa) * 64'(e.opb));
      default: e.alu = 32'd0;
    endcase
    if (op == 6'h34)      e.cnd = (ra == 32'd0);
    else if (op == 6'h35) e.cnd = (ra != 32'd0);
    else                  e.cnd = 1'b0;
    e.npc = npc;
    e.ir  = ir;
    e.bex = rb;
    return e;
  endfunction

  // Drive one instruction, log its expected result, probe the operand muxes.
  task automatic apply(input logic [31:0] ra, rb, imm, npc, ir);
    exp_t e;
    @(negedge clk);
    A = ra; B = rb; Imm = imm; NPC_id = npc; IR_id = ir;
    e = model(ra, rb, imm, npc, ir);
    q.push_back(e);
    #1;
    chk("operand_a", dut.a, e.opa);
    chk("operand_b", dut.b, e.opb);
  endtask

  // Monitor: every edge out of reset retires the oldest queued instruction.
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      m = q.pop_front();
      chk("ALU_res", ALU_res, m.alu);
      chk("cond", {31'd0, cond}, {31'd0, m.cnd});
      chk("B_ex", B_ex, m.bex);
      chk("IR_ex", IR_ex, m.ir);
      chk("NPC_ex", NPC_ex, m.npc);
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_NPC_ex"}, NPC_ex, 32'd0);
    chk({name, "_IR_ex"}, IR_ex, 32'd0);
    chk({name, "_ALU_res"}, ALU_res, 32'd0);
    chk({name, "_B_ex"}, B_ex, 32'd0);
    chk({name, "_cond"}, {31'd0, cond}, 32'd0);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  logic [5:0] ops [14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h30, 6'h34};

  initial begin
    logic [31:0] ir, ra;
    // Reset with nonzero inputs: outputs clear and hold across edges.
    A = 32'd5; B = 32'd3; Imm = 32'd2; NPC_id = 32'h100; IR_id = 32'h0;
    #3;
    chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // RR and RI sweeps, load/store, branches.
    for (int i = 0; i < 6; i++) apply(32'd5, 32'd3, 32'd2, 32'h100, 32'(i) << 26);
    for (int i = 0; i < 6; i++) apply(32'd5, 32'd3, 32'd2, 32'h100, 32'h4000_0000 + (32'(i) << 26));
    apply(32'd5, 32'd3, 32'd2, 32'h100, 32'hC000_0000);
    apply(32'd5, 32'd3, 32'd2, 32'h100, 32'hC400_0000);
    apply(32'd5, 32'd3, 32'd2, 32'h100, 32'hD000_0000);
    apply(32'd5, 32'd3, 32'd2, 32'h100, 32'hD400_0000);
    apply(32'd0, 32'd3, 32'd2, 32'h100, 32'hD000_0000);
    apply(32'd0, 32'd3, 32'd2, 32'h100, 32'hD400_0000);
    // Edge values and undecoded opcodes.
    apply(32'hFFFF_FFFF, 32'd1, 32'd2, 32'h100, 32'h1000_0000);
    apply(32'hFFFF_FFFF, 32'd1, 32'd2, 32'h100, 32'h0000_0000);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 32'h100, 32'h1000_0000);
    apply(32'd5, 32'd3, 32'd2, 32'h100, 32'hFC00_0000);
    apply(32'd5, 32'd3, 32'd2, 32'h100, 32'h1800_0000);
    drain();

    // Mid-stream reset: the instruction presented before the edge is lost.
    apply(32'd9, 32'd4, 32'd1, 32'h200, 32'h0000_0000);
    @(negedge clk);
    A = 32'd7; B = 32'd7; IR_id = 32'h0400_0000;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    chk_zero("rst_mid_edge");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) ir = $urandom();
      else ir = {ops[$urandom_range(0, 13)] | (($urandom_range(0, 1) == 1 &&
                 ops[0] == 6'h00) ? 6'h00 : 6'h00), 26'($urandom())};
      if (ir[31:26] == 6'h30 && $urandom_range(0, 1) == 1) ir[26] = 1'b1;
      if (ir[31:26] == 6'h34 && $urandom_range(0, 1) == 1) ir[26] = 1'b1;
      ra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      apply(ra, $urandom(), $urandom(), $urandom(), ir);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
